multu_sequencer: RTL

- Sequencing controller for the ALU's iterative shift-add unsigned multiplier, with the architectural HI/LO register pair.
- Accepts a one-cycle issue (Signal = MULTU with start) and runs one add/shift iteration per clock until the product is complete.
- Commits the product to HI/LO and pulses done; holds busy for pipeline interlock.
- Also serves MFHI/MFLO reads and MTHI/MTLO writes.

---
 rtl/multu_sequencer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/multu_sequencer.sv
// multu_sequencer
//   Sequencing controller for an iterative shift-add unsigned multiplier,
//   holding the architectural HI/LO pair. A MULTU issue runs one add/shift
//   iteration per clock, commits the product to {HI,LO} and pulses done.
//   MTHI/MTLO write HI/LO while idle; MFHI/MFLO read the committed values.
//
//   state | meaning
//   IDLE  | accepting MULTU / MTHI / MTLO issues
//   RUN   | one add/shift iteration per clock
//   DONE  | product committed, done pulse, back to IDLE next edge
//
// Ports
//   clk      clock, rising edge
//   reset    synchronous active-low reset
//   start    issue strobe, qualified by Signal
//   Signal   function code (MULTU, MFHI, MTHI, MFLO, MTLO)
//   dataA    multiplicand (MULTU) / write data (MTHI, MTLO)
//   dataB    multiplier (MULTU)
//   busy     multiply in flight (RUN or DONE)
//   done     one-cycle pulse after the product is committed
//   dataOut  committed {HI,LO}
//   rdata    HI for MFHI, LO for MFLO, else 0
module multu_sequencer #(
    parameter int WIDTH      = 32,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [5:0]         Signal,
    input  logic [WIDTH-1:0]   dataA,
    input  logic [WIDTH-1:0]   dataB,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] dataOut,
    output logic [WIDTH-1:0]   rdata
);

    localparam logic [5:0] SIG_MULTU = 6'b011001;
    localparam logic [5:0] SIG_MFHI  = 6'b010000;
    localparam logic [5:0] SIG_MTHI  = 6'b010001;
    localparam logic [5:0] SIG_MFLO  = 6'b010010;
    localparam logic [5:0] SIG_MTLO  = 6'b010011;
    localparam int         CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_next;
    logic [2*WIDTH-1:0] acc, mcand, acc_sum;
    logic [WIDTH-1:0]   mplier, hi, lo;
    logic [CW-1:0]      cnt;
    logic               load, wr_hi, wr_lo, finish, last_iter;

    // This iteration's partial sum; also the value committed on the last one.
    assign acc_sum   = mplier[0] ? (acc + mcand) : acc;
    assign last_iter = (cnt == CW'(WIDTH - 1)) ||
                       (EARLY_EXIT && ((mplier >> 1) == '0));

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        wr_hi      = 1'b0;
        wr_lo      = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    case (Signal)
                        SIG_MULTU: begin
                            load       = 1'b1;
                            state_next = RUN;
                        end
                        SIG_MTHI: wr_hi = 1'b1;
                        SIG_MTLO: wr_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (last_iter) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            if (load) begin
                mcand  <= {{WIDTH{1'b0}}, dataA};
                mplier <= dataB;
                acc    <= '0;
                cnt    <= '0;
            end else if (state == RUN) begin
                acc    <= acc_sum;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CW'(1);
            end
            if (finish) {hi, lo} <= acc_sum;
            if (wr_hi)  hi <= dataA;
            if (wr_lo)  lo <= dataA;
        end
    end

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign dataOut = {hi, lo};

    always_comb begin
        rdata = '0;
        if (Signal == SIG_MFHI)      rdata = hi;
        else if (Signal == SIG_MFLO) rdata = lo;
    end

endmodule
